// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz screen geometry used by the sync generator and overlay stages.
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 10;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    typedef logic [COORD_W-1:0] coord_t;

    // True when coordinate c lies in [lo, lo+len-1].
    function automatic logic in_window(coord_t c, int unsigned lo, int unsigned len);
        return (32'(c) >= lo) && (32'(c) < lo + len);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate divider: div counts 0..TICK_DIV-1, p_tick marks its last count.
module pixel_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Next divider count, wrapping after TICK_DIV-1.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    // Divider register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters with registered sync, video and frame decode.
module vga_sync_gen #(
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
    parameter logic        SYNC_ACT  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    import vga_timing_pkg::*;

    localparam int unsigned H_PERIOD = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_PERIOD = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t      H_LAST   = coord_t'(H_PERIOD - 1);
    localparam coord_t      V_LAST   = coord_t'(V_PERIOD - 1);

    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   video_on_q, video_on_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_tick_q, frame_tick_d;

    pixel_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_pixel_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Next raster position: step h on each pixel tick, step v when h wraps.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (p_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode from the next position so registered outputs line up with pix_x/pix_y.
    always_comb begin
        video_on_d   = video_on_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        frame_tick_d = p_tick && (h_q == H_LAST) && (v_q == V_LAST);
        if (p_tick) begin
            video_on_d = (32'(h_d) < H_DISPLAY) && (32'(v_d) < V_DISPLAY);
            hsync_d    = in_window(h_d, H_DISPLAY + H_FRONT, H_SYNC) ? SYNC_ACT : ~SYNC_ACT;
            vsync_d    = in_window(v_d, V_DISPLAY + V_FRONT, V_SYNC) ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    // Counter and output registers, all returned to idle by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q          <= '0;
            v_q          <= '0;
            video_on_q   <= 1'b0;
            hsync_q      <= ~SYNC_ACT;
            vsync_q      <= ~SYNC_ACT;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            video_on_q   <= video_on_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pix_x      = h_q;
    assign pix_y      = v_q;
    assign video_on   = video_on_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a shrunken-geometry instance covers whole frames, a full-size
// instance covers several complete 640x480 lines; both share random reset pulses.
module tb_vga_sync_gen;

    import vga_timing_pkg::*;

    // Shrunken geometry so multiple frames fit in a short run.
    localparam int unsigned ST  = 4;
    localparam int unsigned SHD = 20, SHF = 3, SHS = 4, SHB = 5;
    localparam int unsigned SVD = 12, SVF = 2, SVS = 2, SVB = 3;

    typedef struct packed {
        logic [31:0] n;
        logic [24:0] s;
        logic [24:0] b;
    } exp_t;

    logic clk;
    logic reset;

    logic       s_pt, s_vid, s_hs, s_vs, s_ft;
    logic [9:0] s_x, s_y;
    logic       b_pt, b_vid, b_hs, b_vs, b_ft;
    logic [9:0] b_x, b_y;

    exp_t        sb_q[$];
    int unsigned vectors;
    int unsigned miscompares;

    vga_sync_gen #(
        .TICK_DIV  (ST),
        .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_DISPLAY (SVD), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .SYNC_ACT  (1'b0)
    ) u_small (
        .clk (clk), .reset (reset), .p_tick (s_pt), .pix_x (s_x), .pix_y (s_y),
        .video_on (s_vid), .hsync (s_hs), .vsync (s_vs), .frame_tick (s_ft)
    );

    vga_sync_gen u_full (
        .clk (clk), .reset (reset), .p_tick (b_pt), .pix_x (b_x), .pix_y (b_y),
        .video_on (b_vid), .hsync (b_hs), .vsync (b_vs), .frame_tick (b_ft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [24:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Expected outputs n clocks after reset release, from raster arithmetic.
    function automatic logic [24:0] model(int unsigned n, int unsigned t,
                                          int unsigned hd, int unsigned hf, int unsigned hs, int unsigned hb,
                                          int unsigned vd, int unsigned vf, int unsigned vs, int unsigned vb);
        int unsigned ht, vt, p, x, y;
        logic pt, vid, hsy, vsy, ft;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        p   = n / t;
        x   = p % ht;
        y   = (p / ht) % vt;
        pt  = (n % t) == t - 1;
        vid = (p > 0) && (x < hd) && (y < vd);
        hsy = !((x >= hd + hf) && (x < hd + hf + hs));
        vsy = !((y >= vd + vf) && (y < vd + vf + vs));
        ft  = (p > 0) && ((n % t) == 0) && (x == 0) && (y == 0);
        return {pt, 10'(x), 10'(y), vid, hsy, vsy, ft};
    endfunction

    task automatic push_run(input int unsigned n);
        exp_t e;
        e.n = n;
        e.s = model(n, ST, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB);
        e.b = model(n, 4, H_DISPLAY, H_FRONT, H_SYNC, H_BACK, V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
        sb_q.push_back(e);
    endtask

    task automatic push_reset();
        exp_t e;
        e.n = 32'hFFFF_FFFF;
        e.s = RESET_VEC;
        e.b = RESET_VEC;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] n, input logic [24:0] got, input logic [24:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s n=%0d got pt=%b x=%0d y=%0d vid=%b hs=%b vs=%b ft=%b required pt=%b x=%0d y=%0d vid=%b hs=%b vs=%b ft=%b",
                         name, n, got[24], got[23:14], got[13:4], got[3], got[2], got[1], got[0],
                         exp[24], exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every falling edge, pop one expectation and compare both instances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("small", e.n, {s_pt, s_x, s_y, s_vid, s_hs, s_vs, s_ft}, e.s);
                check("full",  e.n, {b_pt, b_x, b_y, b_vid, b_hs, b_vs, b_ft}, e.b);
            end
        end
    end

    // Stimulus: reset changes land 1ns after a rising edge, i.e. between clock edges.
    initial begin
        int unsigned n;
        int unsigned len;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            push_reset();
        end
        for (int phase = 0; phase < 7; phase++) begin
            @(posedge clk); #1;
            reset = 1'b1;
            n     = 0;
            push_run(n);
            len = (phase == 0) ? 14000 : $urandom_range(300, 6000);
            for (int unsigned i = 1; i < len; i++) begin
                @(posedge clk); #1;
                n++;
                push_run(n);
            end
            @(posedge clk); #1;
            reset = 1'b0;
            push_reset();
            repeat ($urandom_range(1, 5)) begin
                @(posedge clk); #1;
                push_reset();
            end
        end
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
